// File: rtl/tick_counter_pkg.sv
// Shared widths and constants for the tick counter.
// Period counter width and BCD digit layout.
package tick_counter_pkg;

  localparam int TM_W       = 27;
  localparam int BCD_DIGITS = 4;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef logic [3:0]      digit_t;
  typedef logic [TM_W-1:0] tm_t;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the tick count.
// Carry is combinational so a whole 9999 chain ripples in one edge.
module bcd_digit
  import tick_counter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   inc,
  output digit_t digit,
  output logic   carry
);

  logic at_max;

  assign at_max = (digit == DIGIT_MAX);
  assign carry  = inc & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= at_max ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Programmable-period tick generator with LED toggle,
// four-digit BCD tick count and sticky overflow flag.
module tick_counter
  import tick_counter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  tm_t         tm_value,
  input  logic        count_en,
  input  logic        clr,
  output logic        tick,
  output logic        led,
  output logic [15:0] bcd,
  output logic        ovf
);

  tm_t                   cnt;
  logic                  period_end;
  logic [BCD_DIGITS:0]   chain;

  // >= rather than == so a lowered terminal count never wraps cnt
  assign period_end = count_en & ~clr & (cnt >= tm_value);
  assign chain[0]   = period_end;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (chain[i]),
      .digit (bcd[4*i +: 4]),
      .carry (chain[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
      led  <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      tick <= period_end;
      if (count_en) begin
        cnt <= period_end ? '0 : cnt + 1'b1;
      end
      if (period_end) begin
        led <= ~led;
      end
      if (chain[BCD_DIGITS]) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tick_counter.md
TICK_COUNTER -- requirements
Module: tick_counter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port tm_value, input, 27 bits: terminal count from the mode selector; tick period = tm_value+1 clk cycles.
REQ-004 SHALL have port count_en, input, 1 bit: count enable from the mode selector; low = freeze all counting.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear of the period counter, BCD value and overflow flag.
REQ-006 SHALL have port tick, output, 1 bit: registered one-cycle pulse at each period end.
REQ-007 SHALL have port led, output, 1 bit: registered level that toggles on every tick.
REQ-008 SHALL have port bcd, output, 16 bits: four BCD digits; [3:0] = units, [15:12] = thousands.
REQ-009 SHALL have port ovf, output, 1 bit: sticky flag, set when bcd wraps from 9999 to 0000.

Function
REQ-010 SHALL hold a 27-bit period counter cnt, internal, reset 0.
REQ-011 With count_en=1 and cnt>=tm_value: SHALL load cnt<=0 and set tick<=1 on the same edge.
REQ-012 With count_en=1 and cnt<tm_value: SHALL set cnt<=cnt+1 and tick<=0.
REQ-013 With count_en=0: SHALL hold cnt, led and bcd, and drive tick<=0.
REQ-014 tm_value=0 with count_en=1: SHALL assert tick on every cycle; led toggles every cycle.
REQ-015 tm_value lowered below cnt mid-period: SHALL take the cnt>=tm_value branch on the next enabled edge (tick, cnt<=0); no wrap through 2^27.
REQ-016 tm_value raised mid-period: SHALL take effect immediately; the current period extends to the new value.
REQ-017 Tick latency: the tick pulse SHALL be visible in the cycle after the edge at which the period-end condition was sampled; led and bcd update on the same edge that asserts tick.
REQ-018 Each asserted tick SHALL increment bcd by one in decimal; a digit at 9 SHALL become 0 and carry into the next digit on the same edge.
REQ-019 bcd=9999 plus a tick: SHALL give bcd=0000 and ovf<=1; ovf stays 1 until clr or rst.
REQ-020 clr=1: SHALL force cnt<=0, tick<=0, bcd<=0, ovf<=0; led SHALL hold its value.
REQ-021 clr=1 together with a period-end condition: clr SHALL win; no tick, no bcd increment, no led toggle.
REQ-022 clr SHALL act regardless of count_en.
REQ-023 No BCD digit SHALL ever hold a value above 9.

Reset
REQ-024 rst=1 SHALL asynchronously force cnt=0, tick=0, led=0, bcd=16'h0000, ovf=0.
REQ-025 Reset asserted mid-period SHALL discard the partial count; after release the first tick arrives tm_value+1 enabled cycles later.
REQ-026 All outputs SHALL be registered; no combinational path from an input to an output.

Structure
REQ-027 A shared package SHALL define TM_W=27, BCD_DIGITS=4 and DIGIT_MAX=9.
REQ-028 The per-digit counter SHALL be one sub-module, bcd_digit, instantiated four times.
REQ-029 bcd_digit ports SHALL be: clk, rst, clr, inc (in), digit[3:0] (out), carry (out, combinational: inc and digit==9).

Verification
REQ-030 tm_value=4, count_en=1 from reset release: tick SHALL pulse every 5 cycles; led SHALL toggle at each pulse; bcd SHALL read 0003 after the third tick.
REQ-031 tm_value=0, count_en=1 for 12 cycles: tick SHALL be high 12 consecutive cycles; bcd SHALL read 0012.
REQ-032 tm_value=9 with cnt=7, then tm_value changed to 3: tick SHALL pulse on the next edge and cnt SHALL restart at 0.
REQ-033 bcd preset by ticking to 9999 via tm_value=0, then one more tick: bcd SHALL read 0000 and ovf=1; a following clr SHALL give ovf=0.
REQ-034 clr asserted in the cycle of a period end, and count_en dropped for 10 cycles mid-period: no tick in either case, and cnt SHALL be held unchanged while count_en is low.
REQ-035 rst pulsed asynchronously between clock edges while bcd=0042: all outputs SHALL go to 0 before the next edge.
